// File: rtl/branch_predictor_gen.sv
// Dynamic branch predictor for the 5-stage MIPS pipeline.
// Selectable bimodal / gshare / tournament prediction in Fetch, resolution
// and table training from Memory, misprediction redirect/flush and
// saturating performance counters. Tables not needed by MODE are not built.

// One table of saturating counters: a combinational read port for Fetch,
// a read-modify-write port for training.
module bp_ctr_table #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_en,
  input  logic             wr_up,
  output logic [CNT_W-1:0] wr_cnt
);
  localparam int DEPTH = 1 << IDX_W;
  // Weak "low" state: MSB clear, all other bits set.
  localparam logic [CNT_W-1:0] INIT = CNT_W'((1 << (CNT_W-1)) - 1);

  logic [DEPTH-1:0][CNT_W-1:0] tab_q;
  logic [CNT_W-1:0]            ent_d;

  // Fetch reads the pre-update value; there is deliberately no bypass.
  assign rd_cnt = tab_q[rd_idx];
  assign wr_cnt = tab_q[wr_idx];

  // Saturating one-step move of the trained entry.
  always_comb begin
    ent_d = wr_cnt;
    if (wr_up && (wr_cnt != {CNT_W{1'b1}}))
      ent_d = wr_cnt + CNT_W'(1);
    else if (!wr_up && (wr_cnt != '0))
      ent_d = wr_cnt - CNT_W'(1);
  end

  // Table storage; reset forces every entry to the weak low state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) tab_q[i] <= INIT;
    end else if (wr_en) begin
      tab_q[wr_idx] <= ent_d;
    end
  end
endmodule

module branch_predictor_gen #(
  parameter int IDX_W  = 6,
  parameter int GHR_W  = 6,
  parameter int CNT_W  = 2,
  parameter int MODE   = 2,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pcF,
  output logic              pred_takenF,
  output logic [GHR_W-1:0]  ghr_snapF,
  input  logic              resolve_valid,
  input  logic [31:0]       resolve_pc,
  input  logic [GHR_W-1:0]  resolve_ghr,
  input  logic              resolve_taken,
  input  logic              resolve_pred,
  input  logic [31:0]       resolve_fpc,
  output logic              pmis,
  output logic [31:0]       redirect_pc,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mis_cnt
);
  localparam int MSB = CNT_W - 1;

  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [STAT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  logic [IDX_W-1:0] bi_f, gi_f, bi_r, gi_r;
  logic [CNT_W-1:0] b_f, b_r, g_f, g_r, c_f, c_r;
  logic             pred_sel, mis_w;

  // Fetch uses the live history; training uses the snapshot that travelled
  // with the branch, so speculative history never needs repair.
  assign bi_f = pcF[IDX_W+1:2];
  assign gi_f = bi_f ^ IDX_W'(ghr_q);
  assign bi_r = resolve_pc[IDX_W+1:2];
  assign gi_r = bi_r ^ IDX_W'(resolve_ghr);

  if (MODE != 1) begin : g_bim
    bp_ctr_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_pht_b (
      .clk(clk), .rst(rst), .rd_idx(bi_f), .rd_cnt(b_f),
      .wr_idx(bi_r), .wr_en(resolve_valid), .wr_up(resolve_taken), .wr_cnt(b_r)
    );
  end else begin : g_no_bim
    assign b_f = '0;
    assign b_r = '0;
  end

  if (MODE != 0) begin : g_gsh
    bp_ctr_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_pht_g (
      .clk(clk), .rst(rst), .rd_idx(gi_f), .rd_cnt(g_f),
      .wr_idx(gi_r), .wr_en(resolve_valid), .wr_up(resolve_taken), .wr_cnt(g_r)
    );
  end else begin : g_no_gsh
    assign g_f = '0;
    assign g_r = '0;
  end

  // Chooser trains only when the components disagree; up favours gshare.
  if (MODE == 2) begin : g_cho
    bp_ctr_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_chooser (
      .clk(clk), .rst(rst), .rd_idx(bi_f), .rd_cnt(c_f),
      .wr_idx(bi_r), .wr_en(resolve_valid & (b_r[MSB] != g_r[MSB])),
      .wr_up(g_r[MSB] == resolve_taken), .wr_cnt(c_r)
    );
  end else begin : g_no_cho
    assign c_f = '0;
    assign c_r = '0;
  end

  // Component selection for the Fetch prediction.
  always_comb begin
    pred_sel = b_f[MSB];
    if (MODE == 1)      pred_sel = g_f[MSB];
    else if (MODE == 2) pred_sel = c_f[MSB] ? g_f[MSB] : b_f[MSB];
  end

  // Outputs are forced quiet while reset is held.
  assign pred_takenF = rst & pred_sel;
  assign ghr_snapF   = ghr_q;
  assign mis_w       = rst & resolve_valid & (resolve_taken ^ resolve_pred);
  assign pmis        = mis_w;
  assign redirect_pc = mis_w ? resolve_fpc : 32'h0;
  assign flushD      = mis_w;
  assign flushE      = mis_w;
  assign flushM      = mis_w;
  assign branch_cnt  = bcnt_q;
  assign mis_cnt     = mcnt_q;

  // History shift and saturating statistics.
  always_comb begin
    ghr_d  = ghr_q;
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (resolve_valid) begin
      ghr_d = GHR_W'({ghr_q, resolve_taken});
      if (bcnt_q != {STAT_W{1'b1}}) bcnt_d = bcnt_q + STAT_W'(1);
      if (mis_w && (mcnt_q != {STAT_W{1'b1}})) mcnt_d = mcnt_q + STAT_W'(1);
    end
  end

  // History and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q  <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  // Bits that are legitimately ignored in some modes.
  logic unused_sig;
  assign unused_sig = ^{pcF[31:IDX_W+2], pcF[1:0], resolve_pc[31:IDX_W+2],
                        resolve_pc[1:0], gi_f, gi_r, b_f, b_r, g_f, g_r, c_f, c_r};
endmodule

// File: tb/tb_branch_predictor_gen.sv
// Scoreboard bench: the same stimulus drives one predictor per MODE; a
// table-level reference model supplies expected outputs, a monitor compares.
module tb_branch_predictor_gen;
  localparam int IDX_W = 6, GHR_W = 6, CNT_W = 2, STAT_W = 7;
  localparam int N = 1 << IDX_W;
  localparam int SMAX = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic rst, rv, rt, rp;
  logic [31:0] pcF, rpc, rfpc;
  logic [GHR_W-1:0] rghr;

  logic              pred [3];
  logic [GHR_W-1:0]  snap [3];
  logic              pm [3], fd [3], fe [3], fm [3];
  logic [31:0]       rdp [3];
  logic [STAT_W-1:0] bc [3], mc [3];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    branch_predictor_gen #(.IDX_W(IDX_W), .GHR_W(GHR_W), .CNT_W(CNT_W),
                           .MODE(m), .STAT_W(STAT_W)) u_dut (
      .clk(clk), .rst(rst), .pcF(pcF), .pred_takenF(pred[m]), .ghr_snapF(snap[m]),
      .resolve_valid(rv), .resolve_pc(rpc), .resolve_ghr(rghr),
      .resolve_taken(rt), .resolve_pred(rp), .resolve_fpc(rfpc),
      .pmis(pm[m]), .redirect_pc(rdp[m]), .flushD(fd[m]), .flushE(fe[m]),
      .flushM(fm[m]), .branch_cnt(bc[m]), .mis_cnt(mc[m])
    );
  end

  typedef struct {
    logic [2:0] pred;
    int snap, bcnt, mcnt;
    logic pmis;
    logic [31:0] rpc;
  } exp_t;
  exp_t sb[$];

  // Reference model: counter values as plain integers 0..3.
  int mb[N], mg[N], mch[N];
  int mghr, mbc, mmc;
  int compared = 0, mismatched = 0;

  function automatic int step(int c, bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic int bidx(logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mb[i] = 1; mg[i] = 1; mch[i] = 1; end
    mghr = 0; mbc = 0; mmc = 0;
  endtask

  task automatic issue(bit r, bit v, logic [31:0] pf, logic [31:0] p,
                       int g, bit t, bit pr, logic [31:0] fpc);
    exp_t e;
    int bi, gi, rb, rg;
    bit pb, pg, mis, ob, og;
    @(posedge clk); #1;
    rst = r; rv = v; pcF = pf; rpc = p; rghr = GHR_W'(g);
    rt = t; rp = pr; rfpc = fpc;
    if (!r) model_reset();
    bi = bidx(pf); gi = bi ^ mghr;
    pb = mb[bi] >= 2; pg = mg[gi] >= 2;
    mis = r && v && (t != pr);
    e.pred = r ? {(mch[bi] >= 2) ? pg : pb, pg, pb} : 3'b000;
    e.snap = mghr; e.bcnt = mbc; e.mcnt = mmc;
    e.pmis = mis; e.rpc = mis ? fpc : 32'h0;
    sb.push_back(e);
    if (r && v) begin
      rb = bidx(p); rg = rb ^ (g % N);
      ob = mb[rb] >= 2; og = mg[rg] >= 2;
      if (ob != og) mch[rb] = step(mch[rb], og == t);
      mb[rb] = step(mb[rb], t);
      mg[rg] = step(mg[rg], t);
      mghr = ((mghr << 1) | int'(t)) % (1 << GHR_W);
      if (mbc < SMAX) mbc++;
      if (mis && mmc < SMAX) mmc++;
    end
  endtask

  task automatic chk(string nm, int m, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s mode%0d @%0t: got %0h want %0h", nm, m, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational every cycle; sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int m = 0; m < 3; m++) begin
          chk("pred_takenF", m, 64'(pred[m]), 64'(e.pred[m]));
          chk("ghr_snapF",   m, 64'(snap[m]), 64'(e.snap));
          chk("pmis",        m, 64'(pm[m]),   64'(e.pmis));
          chk("redirect_pc", m, 64'(rdp[m]),  64'(e.rpc));
          chk("flushD",      m, 64'(fd[m]),   64'(e.pmis));
          chk("flushE",      m, 64'(fe[m]),   64'(e.pmis));
          chk("flushM",      m, 64'(fm[m]),   64'(e.pmis));
          chk("branch_cnt",  m, 64'(bc[m]),   64'(e.bcnt));
          chk("mis_cnt",     m, 64'(mc[m]),   64'(e.mcnt));
        end
      end
    end
  end

  initial begin
    logic [31:0] pcs [8];
    logic [31:0] pa, pt, pc;
    int g;
    bit t, pr;
    rst = 1'b0; rv = 1'b0; pcF = '0; rpc = '0; rghr = '0;
    rt = 1'b0; rp = 1'b0; rfpc = '0;
    model_reset();
    for (int i = 0; i < 8; i++) pcs[i] = 32'h0040_0000 + 32'(i * 4 + (i % 3) * 64);

    // Reset state, then release.
    issue(0, 0, 32'h0040_0010, 0, 0, 0, 0, 0);
    issue(0, 1, 32'h0040_0010, 32'h0040_0010, 0, 1, 0, 32'h1234);
    issue(1, 0, 32'h0040_0010, 0, 0, 0, 0, 0);

    // Training, saturation and decay on one PC; pcF on the same entry.
    for (int i = 0; i < 7; i++)
      issue(1, 1, 32'h0040_0010, 32'h0040_0010, mghr, 1, 0, 32'h0040_0100 + 32'(i));
    issue(1, 1, 32'h0040_0010, 32'h0040_0010, mghr, 0, 1, 32'h0040_0200);
    issue(1, 1, 32'h0040_0010, 32'h0040_0010, mghr, 0, 1, 32'h0040_0204);
    issue(1, 0, 32'h0040_0010, 0, 0, 0, 0, 0);

    // Alternating branch interleaved with an always-taken branch; the
    // history snapshot comes from the model and pred from the selected table.
    pa = 32'h0040_0040; pt = 32'h0040_0080;
    for (int i = 0; i < 40; i++) begin
      pc = (i % 4 == 3) ? pt : pa;
      t  = (pc == pt) ? 1'b1 : bit'(i % 2);
      pr = (mch[bidx(pc)] >= 2) ? (mg[bidx(pc) ^ mghr] >= 2) : (mb[bidx(pc)] >= 2);
      issue(1, 1, pc, pc, mghr, t, pr, 32'h0040_1000);
    end
    issue(1, 0, pa, 0, 0, 0, 0, 0);
    issue(1, 0, pt, 0, 0, 0, 0, 0);

    // Randomized traffic with a mid-run reset pulse.
    for (int i = 0; i < 500; i++) begin
      g = ($urandom_range(1, 0) == 1) ? mghr : int'($urandom_range(N - 1, 0));
      issue(i != 120, $urandom_range(9, 0) < 8,
            pcs[$urandom_range(7, 0)], pcs[$urandom_range(7, 0)], g,
            bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)), $urandom);
    end

    @(posedge clk); #1; rv = 1'b0;
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/branch_predictor_gen.md
Name: branch_predictor_gen

Overview:
Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It replaces the fixed single-table predictor and offers three selectable modes: bimodal (PC-indexed), gshare (PC xor global history) and tournament (bimodal and gshare with a per-PC chooser). It predicts in Fetch and accepts resolution from Memory. On a misprediction it raises the redirect and the pipeline flushes; it also keeps performance counters.

Parameters:
IDX_W, 6, PHT index width; each table holds 2^IDX_W entries
GHR_W, 6, global history length in bits; must be <= IDX_W
CNT_W, 2, saturating counter width for PHT and chooser entries
MODE, 2, 0 = bimodal, 1 = gshare, 2 = tournament
STAT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
pcF  in  32  PC of the instruction in Fetch
pred_takenF  out  1  predicted direction for pcF
ghr_snapF  out  GHR_W  history snapshot used for pcF; carried down the pipeline
resolve_valid  in  1  a branch is resolving in Memory this cycle
resolve_pc  in  32  PC of the resolving branch
resolve_ghr  in  GHR_W  snapshot carried with that branch
resolve_taken  in  1  actual direction
resolve_pred  in  1  direction that was predicted
resolve_fpc  in  32  correct next PC if the prediction was wrong
pmis  out  1  misprediction this cycle
redirect_pc  out  32  PC to load when pmis is 1
flushD  out  1  clear F->D register
flushE  out  1  clear D->E register
flushM  out  1  clear E->M register
branch_cnt  out  STAT_W  resolved branches since reset
mis_cnt  out  STAT_W  mispredictions since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - every PHT entry = weakly not-taken (CNT_W'b01..1, MSB 0).
  - every chooser entry = weakly-bimodal (MSB 0).
  - ghr = 0; branch_cnt = mis_cnt = 0.
  - Outputs while in reset: pred_takenF = 0, pmis = 0, flushD/E/M = 0, redirect_pc = 0.
- Index functions:
  - bimodal index bi = pc[IDX_W+1:2].
  - gshare index gi = pc[IDX_W+1:2] xor zero-extended ghr (low GHR_W bits).
  - Prediction uses pcF and the current ghr. Update uses resolve_pc and resolve_ghr, so no speculative-history repair is needed.
- Prediction is combinational, with zero latency in Fetch. pred_takenF = MSB of the selected counter.
  - MODE 0 uses PHT_b[bi]; MODE 1 uses PHT_g[gi].
  - MODE 2 uses PHT_g when chooser[bi] MSB = 1, otherwise PHT_b.
  - ghr_snapF = ghr.
- Unused tables for the chosen MODE are not generated.
- Resolution:
  - pmis = resolve_valid & (resolve_taken != resolve_pred), combinational in the same cycle.
  - redirect_pc = resolve_fpc when pmis = 1, else 0.
  - flushD = flushE = flushM = pmis.
- Update on the rising edge when resolve_valid = 1:
  - The indexed PHT counter(s) move one step toward resolve_taken, saturating at 0 and 2^CNT_W-1. In tournament mode both PHTs update.
  - Chooser updates only when the bimodal and gshare MSBs disagree: it steps toward the correct component (up = gshare), saturating.
  - ghr <= {ghr[GHR_W-2:0], resolve_taken}.
  - branch_cnt increments by 1; mis_cnt increments when pmis = 1. Both saturate at all-ones and do not wrap.
- Same-entry read and write in one cycle: prediction sees the pre-update value; there is no bypass.
- resolve_valid = 0: no state changes, pmis = 0.
- Reset asserted mid-operation: all state clears immediately. The first cycle after release behaves as after power-up.

Test Plan:
- Reset, MODE 0: pcF=0x0040_0010 -> pred_takenF=0, ghr_snapF=0, both counters 0, pmis=0.
- MODE 0 training: resolve pc 0x0040_0010 taken twice with pred=0 -> pmis=1 both cycles, redirect_pc=resolve_fpc, flushD/E/M=1. Then pred_takenF=1 for that pc, mis_cnt=2, branch_cnt=2.
- Saturation: 5 further taken resolves on the same pc -> counter stays 2'b11. One not-taken resolve -> pred_takenF remains 1; a second not-taken -> pred_takenF=0.
- MODE 1 alternating T/N/T/N on one pc, resolve_ghr fed from ghr_snapF -> after warm-up, mispredictions stop and mis_cnt stays constant over 8 more resolves.
- MODE 2: the same alternating pattern -> chooser MSB for that pc becomes 1 and pred_takenF tracks the gshare table. A separate always-taken pc keeps chooser MSB 0.
- Simultaneous resolve_valid with pcF mapping to the same entry -> pred_takenF shows the old counter that cycle and the updated one the next. Pulsing rst low mid-run -> counters and ghr read 0 within the same cycle.
